// File: rtl/nios_req_pkg.sv
// Shared types and default sizes for the NIOS request initiator.
package nios_req_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } req_state_t;

endpackage

// File: rtl/req_event_fifo.sv
// Synchronous event FIFO: head is visible combinationally, level/full/empty
// are derived from a registered occupancy count.
module req_event_fifo
    import nios_req_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEVEL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_level == LEVEL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo the depth.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/nios_request_initiator.sv
// Fabric-side initiator of the four-phase NIOS request/acknowledge handshake.
// req_data is loaded one cycle before req_out rises so the event code is
// already settled when the receiver's edge-capture fires.
module nios_request_initiator
    import nios_req_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int TIMEOUT    = 1000000,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              evt_valid,
    input  logic [DATA_W-1:0] evt_data,
    output logic              evt_ready,
    input  logic              ack_in,
    output logic              req_out,
    output logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_level,
    output logic [7:0]        timeout_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);

    req_state_t        r_state;
    logic              r_ack_meta;
    logic              r_ack_s;
    logic              r_req_out;
    logic [DATA_W-1:0] r_req_data;
    logic [TW-1:0]     r_timer;
    logic [GW-1:0]     r_gap;
    logic [7:0]        r_timeout_cnt;
    logic              r_busy;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    assign evt_ready   = !w_full;
    assign w_push      = evt_valid && !w_full;
    // Only an acknowledge seen while the request is actually visible pops.
    assign w_pop       = (r_state == ST_REQ) && r_req_out && r_ack_s;
    assign req_out     = r_req_out;
    assign req_data    = r_req_data;
    assign busy        = r_busy;
    assign timeout_cnt = r_timeout_cnt;

    req_event_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (evt_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Two-flop synchroniser bringing the software acknowledge into clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= ack_in;
            r_ack_s    <= r_ack_meta;
        end
    end

    // Handshake FSM with request/timeout/gap timing and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_req_out     <= 1'b0;
            r_req_data    <= '0;
            r_timer       <= '0;
            r_gap         <= '0;
            r_timeout_cnt <= 8'd0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_out <= 1'b0;
                    if (!w_empty) begin
                        r_req_data <= w_head;
                        r_timer    <= '0;
                        r_state    <= ST_REQ;
                        r_busy     <= 1'b1;
                    end else begin
                        r_busy <= w_push;
                    end
                end
                ST_REQ: begin
                    r_busy <= 1'b1;
                    if (r_req_out && r_ack_s) begin
                        r_req_out <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end else if (r_req_out && (r_timer == TIMER_LAST)) begin
                        r_req_out <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= ST_GAP;
                        if (r_timeout_cnt != 8'hFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end else begin
                        // Timer counts only cycles in which the request is visible.
                        r_req_out <= 1'b1;
                        if (r_req_out) begin
                            r_timer <= r_timer + TIMER_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_req_out <= 1'b0;
                    r_busy    <= 1'b1;
                    if (!r_ack_s) begin
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_req_out <= 1'b0;
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= w_push || !w_empty;
                    end else begin
                        r_gap  <= r_gap + GAP_ONE;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_req_out <= 1'b0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_request_initiator.sv
// Directed bench for nios_request_initiator (TIMEOUT=16, GAP_CYCLES=4, ADDR_W=2).
module tb_nios_request_initiator;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              evt_valid = 1'b0;
    logic [DATA_W-1:0] evt_data = '0;
    logic              evt_ready;
    logic              ack_in = 1'b0;
    logic              req_out;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic [ADDR_W:0]   fifo_level;
    logic [7:0]        timeout_cnt;

    int errors = 0;
    int checks = 0;

    nios_request_initiator #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT    (16),
        .GAP_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .ack_in      (ack_in),
        .req_out     (req_out),
        .req_data    (req_data),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edges;
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       e_req;
        logic [7:0] e_data;
        int         e_lvl;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    vec_t tbl [9];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Waits (bounded) until req_out equals lvl; n returns the edges taken.
    task automatic wait_req(input logic lvl, input int budget, input string nm, output int n);
        n = 0;
        while (req_out !== lvl && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (req_out !== lvl) begin
            errors++;
            $display("FAIL %s: req_out stayed %0b for %0d cycles, expected %0b", nm, req_out, budget, lvl);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, int'(busy), 0);
    endtask

    task automatic push(input logic [7:0] d);
        evt_valid = 1'b1;
        evt_data  = d;
        step(1);
        evt_valid = 1'b0;
    endtask

    // Prompt software acknowledge of one request carrying the expected code.
    task automatic serve(input logic [7:0] exp_d, input string nm);
        int n;
        wait_req(1'b1, 40, {nm, "_rise"}, n);
        chk({nm, "_data"}, int'(req_data), int'(exp_d));
        ack_in = 1'b1;
        wait_req(1'b0, 10, {nm, "_fall"}, n);
        ack_in = 1'b0;
    endtask

    initial begin
        int n;

        // Single event, cycle-accurate (edge 0 = push edge).
        tbl[0] = '{1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b1};
        tbl[1] = '{2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1, 1'b1, 1'b1};
        tbl[2] = '{7, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1, 1'b1, 1'b1};
        tbl[3] = '{2, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1, 1'b1, 1'b1};
        tbl[4] = '{1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 0, 1'b1, 1'b1};
        tbl[5] = '{7, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 0, 1'b1, 1'b1};
        tbl[6] = '{2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 0, 1'b1, 1'b1};
        tbl[7] = '{3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 0, 1'b1, 1'b1};
        tbl[8] = '{2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 0, 1'b0, 1'b1};

        // Reset state.
        step(2);
        chk("rst_req", int'(req_out), 0);
        chk("rst_data", int'(req_data), 0);
        chk("rst_tcnt", int'(timeout_cnt), 0);
        chk("rst_lvl", int'(fifo_level), 0);
        chk("rst_rdy", int'(evt_ready), 1);
        reset_n = 1'b1;
        step(1);
        chk("rst_busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            evt_valid = tbl[i].v;
            evt_data  = tbl[i].d;
            ack_in    = tbl[i].a;
            step(tbl[i].edges);
            chk($sformatf("vec%0d_req", i), int'(req_out), int'(tbl[i].e_req));
            chk($sformatf("vec%0d_data", i), int'(req_data), int'(tbl[i].e_data));
            chk($sformatf("vec%0d_lvl", i), int'(fifo_level), tbl[i].e_lvl);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            chk($sformatf("vec%0d_rdy", i), int'(evt_ready), int'(tbl[i].e_rdy));
        end

        // Backpressure: five consecutive offers, no acknowledge.
        for (int i = 1; i <= 5; i++) begin
            evt_valid = 1'b1;
            evt_data  = 8'(i);
            step(1);
            chk($sformatf("bp_lvl%0d", i), int'(fifo_level), (i < 4) ? i : 4);
            chk($sformatf("bp_rdy%0d", i), int'(evt_ready), (i < 4) ? 1 : 0);
        end
        evt_valid = 1'b0;
        wait_req(1'b1, 10, "bp_first_rise", n);
        chk("bp_first_data", int'(req_data), 1);
        ack_in = 1'b1;
        wait_req(1'b0, 10, "bp_first_fall", n);
        chk("bp_pop_lvl", int'(fifo_level), 3);
        chk("bp_pop_rdy", int'(evt_ready), 1);
        ack_in = 1'b0;
        serve(8'h02, "bp_e2");
        serve(8'h03, "bp_e3");
        serve(8'h04, "bp_e4");
        wait_idle(40, "bp_idle");
        chk("bp_no_e5", int'(fifo_level), 0);

        // Timeout/retry and saturation.
        push(8'h77);
        wait_req(1'b1, 10, "to_rise1", n);
        chk("to_data1", int'(req_data), 8'h77);
        wait_req(1'b0, 40, "to_fall1", n);
        chk("to_high_cycles1", n, 16);
        chk("to_cnt1", int'(timeout_cnt), 1);
        wait_req(1'b1, 20, "to_rise2", n);
        chk_rng("to_low_cycles", n, 4, 6);
        chk("to_data2", int'(req_data), 8'h77);
        chk("to_lvl", int'(fifo_level), 1);
        wait_req(1'b0, 40, "to_fall2", n);
        chk("to_high_cycles2", n, 16);
        chk("to_cnt2", int'(timeout_cnt), 2);
        for (int k = 3; k <= 260; k++) begin
            wait_req(1'b1, 20, "sat_rise", n);
            wait_req(1'b0, 40, "sat_fall", n);
            if (k == 254) begin
                chk("sat_cnt254", int'(timeout_cnt), 254);
            end
        end
        chk("sat_cnt", int'(timeout_cnt), 255);

        // Reset mid-REQ with three queued events.
        push(8'h88);
        push(8'h99);
        wait_req(1'b1, 20, "mr_rise", n);
        chk("mr_lvl_before", int'(fifo_level), 3);
        reset_n = 1'b0;
        step(1);
        chk("mr_req", int'(req_out), 0);
        chk("mr_lvl", int'(fifo_level), 0);
        chk("mr_data", int'(req_data), 0);
        chk("mr_tcnt", int'(timeout_cnt), 0);
        chk("mr_rdy", int'(evt_ready), 1);
        reset_n = 1'b1;
        step(2);

        // Spurious acknowledge while idle and empty.
        ack_in = 1'b1;
        step(3);
        ack_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("sp_req%0d", i), int'(req_out), 0);
        end
        chk("sp_lvl", int'(fifo_level), 0);
        chk("sp_tcnt", int'(timeout_cnt), 0);
        chk("sp_busy", int'(busy), 0);

        // Back-to-back events, each acknowledged promptly.
        push(8'hA1);
        push(8'hA2);
        wait_req(1'b1, 10, "bb_rise1", n);
        chk("bb_data1", int'(req_data), 8'hA1);
        ack_in = 1'b1;
        wait_req(1'b0, 10, "bb_fall1", n);
        ack_in = 1'b0;
        wait_req(1'b1, 30, "bb_rise2", n);
        chk_rng("bb_low_cycles", n, 4, 30);
        chk("bb_data2", int'(req_data), 8'hA2);
        ack_in = 1'b1;
        wait_req(1'b0, 10, "bb_fall2", n);
        ack_in = 1'b0;
        wait_idle(30, "bb_idle");
        chk("bb_lvl", int'(fifo_level), 0);
        chk("bb_tcnt", int'(timeout_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
